// File: rtl/adc_pkg.sv
// Shared types and constants for the multi-channel serial ADC receiver.
// Channel slice offsets are centralised here so top and bench agree on packing.
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam int DEF_NUM_CH     = 2;
  localparam int DEF_FRAME_BITS = 16;
  localparam int DEF_LEAD_BITS  = 4;
  localparam int DEF_DATA_BITS  = 12;
  localparam int DEF_GAP_CYCLES = 2;

  function automatic int ch_lo(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/adc_ch_shift.sv
// One channel's frame shift register, MSB-first, with lead-bit check and
// payload extraction taken straight from the captured frame.
module adc_ch_shift
  import adc_pkg::*;
#(
  parameter int FRAME_BITS = DEF_FRAME_BITS,
  parameter int LEAD_BITS  = DEF_LEAD_BITS,
  parameter int DATA_BITS  = DEF_DATA_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  shift_en,
  input  logic                  sdata,
  output logic [FRAME_BITS-1:0] frame,
  output logic                  lead_nz,
  output logic [DATA_BITS-1:0]  payload
);

  always_ff @(posedge clk) begin
    if (reset) begin
      frame <= '0;
    end else if (shift_en) begin
      frame <= {frame[FRAME_BITS-2:0], sdata};
    end
  end

  assign lead_nz = |frame[FRAME_BITS-1 -: LEAD_BITS];
  assign payload = frame[FRAME_BITS-1-LEAD_BITS -: DATA_BITS];

endmodule

// File: rtl/adc_serial_rx_multi.sv
// Multi-channel serial ADC receiver: drives CS, captures NUM_CH lines in lockstep,
// and publishes payload/lead-error once per frame.
//
// state | meaning
// IDLE  | CS high, waiting for start
// CONV  | CS low, one sample per edge on every channel
// DONE  | CS high, frame complete; outputs latch on this edge
// GAP   | CS high for GAP_CYCLES, then restart if continuous
module adc_serial_rx_multi
  import adc_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int FRAME_BITS = DEF_FRAME_BITS,
  parameter int LEAD_BITS  = DEF_LEAD_BITS,
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic                           SCLK,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           continuous,
  input  logic [NUM_CH-1:0]              sdata,
  output logic                           CS,
  output logic                           busy,
  output logic                           rx_done_tick,
  output logic                           frame_err,
  output logic [NUM_CH*FRAME_BITS-1:0]   b_reg,
  output logic [NUM_CH*DATA_BITS-1:0]    data_out
);

  localparam int BW = $clog2(FRAME_BITS + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  if (LEAD_BITS + DATA_BITS > FRAME_BITS || GAP_CYCLES < 1) begin : g_bad_params
    $error("adc_serial_rx_multi: illegal FRAME/LEAD/DATA/GAP parameter combination");
  end

  state_t             state, state_n;
  logic [BW-1:0]      bit_cnt;
  logic [GW-1:0]      gap_cnt;
  logic               shift_en;
  logic [NUM_CH-1:0]  lead_nz;
  logic [NUM_CH*DATA_BITS-1:0] payload;

  assign shift_en = (state == CONV);
  assign busy     = (state != IDLE);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam int FLO = ch_lo(c, FRAME_BITS);
    localparam int DLO = ch_lo(c, DATA_BITS);
    adc_ch_shift #(
      .FRAME_BITS(FRAME_BITS),
      .LEAD_BITS (LEAD_BITS),
      .DATA_BITS (DATA_BITS)
    ) u_ch (
      .clk     (SCLK),
      .reset   (reset),
      .shift_en(shift_en),
      .sdata   (sdata[c]),
      .frame   (b_reg[FLO +: FRAME_BITS]),
      .lead_nz (lead_nz[c]),
      .payload (payload[DLO +: DATA_BITS])
    );
  end

  always_ff @(posedge SCLK) begin
    if (reset) begin
      state <= IDLE;
      CS    <= 1'b1;
    end else begin
      state <= state_n;
      CS    <= (state_n != CONV);
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = CONV;
      CONV:    if (bit_cnt == BIT_LAST) state_n = DONE;
      DONE:    state_n = GAP;
      GAP:     if (gap_cnt == GAP_LAST) state_n = continuous ? CONV : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs latch on the DONE edge so the tick and new data_out appear together.
  always_ff @(posedge SCLK) begin
    if (reset) begin
      bit_cnt      <= '0;
      gap_cnt      <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
      data_out     <= '0;
    end else begin
      rx_done_tick <= (state == DONE);
      if (state != CONV && state_n == CONV) begin
        bit_cnt <= '0;
      end else if (state == CONV) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (state == DONE) begin
        gap_cnt   <= '0;
        data_out  <= payload;
        frame_err <= |lead_nz;
      end else if (state == GAP) begin
        gap_cnt <= gap_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adc_serial_rx_multi.sv
// Self-checking bench: behavioural ADC drives frames, a monitor logs CS runs
// and ticks, and each test compares against frame arithmetic.
module tb_adc_serial_rx_multi;

  localparam int NC = 2;
  localparam int FB = 16;
  localparam int LB = 4;
  localparam int DB = 12;
  localparam int GC = 2;

  logic SCLK = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic continuous = 1'b0;
  logic [NC-1:0] sdata = '0;
  logic CS, busy, rx_done_tick, frame_err;
  logic [NC*FB-1:0] b_reg;
  logic [NC*DB-1:0] data_out;

  int checks = 0;
  int errors = 0;

  adc_serial_rx_multi #(
    .NUM_CH(NC), .FRAME_BITS(FB), .LEAD_BITS(LB), .DATA_BITS(DB), .GAP_CYCLES(GC)
  ) dut (
    .SCLK(SCLK), .reset(reset), .start(start), .continuous(continuous), .sdata(sdata),
    .CS(CS), .busy(busy), .rx_done_tick(rx_done_tick), .frame_err(frame_err),
    .b_reg(b_reg), .data_out(data_out)
  );

  always #5 SCLK = ~SCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: payload sits right below the lead bits; error if any lead bit set.
  function automatic logic [DB-1:0] ref_data(input logic [FB-1:0] f);
    int v;
    v = int'(f);
    return DB'((v >> (FB - LB - DB)) % (1 << DB));
  endfunction

  function automatic logic ref_err(input logic [FB-1:0] f);
    return ((int'(f) >> (FB - LB)) != 0);
  endfunction

  // ADC model: presents the next frame bit after each falling edge while CS is low.
  logic [FB-1:0] q0[$], q1[$];
  logic [FB-1:0] cur0 = '0, cur1 = '0;
  int idx = 0;
  always @(negedge SCLK) begin
    if (CS === 1'b0) begin
      if (idx == 0) begin
        if (q0.size() > 0) cur0 = q0.pop_front();
        else cur0 = FB'($urandom_range(0, 4095));
        if (q1.size() > 0) cur1 = q1.pop_front();
        else cur1 = FB'($urandom_range(0, 4095));
      end
      sdata = {cur1[FB-1-idx], cur0[FB-1-idx]};
      idx = (idx + 1) % FB;
    end else begin
      idx = 0;
      sdata = NC'($urandom);
    end
  end

  // Monitor: samples 1 ns after the active edge.
  int cyc = 0;
  logic cs_prev = 1'b1;
  bit seen_low = 0;
  int low_run = 0, high_run = 0, fall_cnt = 0;
  int low_q[$], high_q[$], fcyc[$], tcyc[$];
  logic [DB-1:0] od0[$], od1[$];
  logic oerr[$];
  always @(posedge SCLK) begin
    #1;
    cyc++;
    if (CS === 1'b0) begin
      if (cs_prev !== 1'b0) begin
        fall_cnt++;
        fcyc.push_back(cyc);
        if (seen_low) high_q.push_back(high_run);
        high_run = 0;
      end
      low_run++;
    end else begin
      if (cs_prev === 1'b0) begin
        low_q.push_back(low_run);
        low_run = 0;
        seen_low = 1;
      end
      high_run++;
    end
    cs_prev = CS;
    if (rx_done_tick === 1'b1) begin
      od0.push_back(data_out[0 +: DB]);
      od1.push_back(data_out[DB +: DB]);
      oerr.push_back(frame_err);
      tcyc.push_back(cyc);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge SCLK);
      #2;
    end
  endtask

  task automatic clear_mon();
    low_q.delete(); high_q.delete(); fcyc.delete(); tcyc.delete();
    od0.delete(); od1.delete(); oerr.delete();
    fall_cnt = 0; seen_low = 0; low_run = 0; high_run = 0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (busy === 1'b0) begin
        ok = 1;
        break;
      end
      step(1);
    end
  endtask

  task automatic run_single(input logic [FB-1:0] f0, input logic [FB-1:0] f1, output bit ok);
    q0.push_back(f0);
    q1.push_back(f1);
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_idle(ok);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      checks++;
      if ({CS, busy, rx_done_tick, frame_err} !== 4'b1000 || b_reg !== '0 || data_out !== '0) begin
        errors++;
        $display("FAIL reset_state cyc%0d: got cs/busy/tick/err=%b b_reg=%h data=%h want 1000/0/0",
                 i, {CS, busy, rx_done_tick, frame_err}, b_reg, data_out);
      end
    end
    checks++;
    if (fall_cnt !== 0) begin
      errors++;
      $display("FAIL reset_no_cs_fall: got %0d falls want 0", fall_cnt);
    end
    reset = 1'b0;
    start = 1'b0;
    step(3);
    checks++;
    if (busy !== 1'b0 || CS !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_idle: got busy=%b cs=%b want 0 1", busy, CS);
    end
    clear_mon();
  endtask

  task automatic test_single_shot();
    bit ok;
    clear_mon();
    continuous = 1'b0;
    run_single(16'h0ABC, 16'h0123, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_timeout: got busy=%b want 0", busy); end
    checks++;
    if (od0.size() !== 1) begin errors++; $display("FAIL single_tick_count: got %0d want 1", od0.size()); end
    checks++;
    if (od0[0] !== 12'hABC || od1[0] !== 12'h123) begin
      errors++;
      $display("FAIL single_data: got %h/%h want abc/123", od0[0], od1[0]);
    end
    checks++;
    if (oerr[0] !== 1'b0) begin errors++; $display("FAIL single_err: got %b want 0", oerr[0]); end
    checks++;
    if (low_q[0] !== FB) begin errors++; $display("FAIL single_cs_low: got %0d want %0d", low_q[0], FB); end
    checks++;
    if (tcyc[0] - fcyc[0] !== FB + 1) begin
      errors++;
      $display("FAIL single_tick_latency: got %0d want %0d", tcyc[0] - fcyc[0], FB + 1);
    end
    checks++;
    if (b_reg !== {16'h0123, 16'h0ABC}) begin
      errors++;
      $display("FAIL single_b_reg: got %h want 01230abc", b_reg);
    end
    step(4);
    checks++;
    if (data_out !== {12'h123, 12'hABC} || CS !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_hold: got data=%h cs=%b busy=%b want 123abc 1 0", data_out, CS, busy);
    end
  endtask

  task automatic test_lead_err();
    bit ok;
    logic [FB-1:0] f0, f1;
    clear_mon();
    run_single(16'h0456, 16'h8123, ok);
    checks++;
    if (!ok || oerr[0] !== 1'b1 || od1[0] !== 12'h123 || od0[0] !== 12'h456) begin
      errors++;
      $display("FAIL lead_err_set: got ok=%b err=%b data=%h/%h want 1 1 456/123", ok, oerr[0], od0[0], od1[0]);
    end
    clear_mon();
    f0 = FB'($urandom_range(0, 4095));
    f1 = FB'($urandom_range(0, 4095));
    run_single(f0, f1, ok);
    checks++;
    if (!ok || frame_err !== 1'b0 || data_out !== {ref_data(f1), ref_data(f0)}) begin
      errors++;
      $display("FAIL lead_err_clear: got ok=%b err=%b data=%h want 1 0 %h%h", ok, frame_err, data_out,
               ref_data(f1), ref_data(f0));
    end
  endtask

  task automatic test_random_frames();
    bit ok;
    logic [FB-1:0] f0, f1;
    for (int i = 0; i < 6; i++) begin
      clear_mon();
      f0 = ($urandom_range(0, 1) == 1) ? FB'($urandom) : FB'($urandom_range(0, 4095));
      f1 = ($urandom_range(0, 1) == 1) ? FB'($urandom) : FB'($urandom_range(0, 4095));
      run_single(f0, f1, ok);
      checks++;
      if (!ok || od0.size() !== 1 || od0[0] !== ref_data(f0) || od1[0] !== ref_data(f1)
          || oerr[0] !== (ref_err(f0) | ref_err(f1))) begin
        errors++;
        $display("FAIL random_frame%0d: got data=%h/%h err=%b ticks=%0d want %h/%h %b 1", i, od0[0], od1[0],
                 oerr[0], od0.size(), ref_data(f0), ref_data(f1), ref_err(f0) | ref_err(f1));
      end
    end
  endtask

  task automatic test_continuous();
    bit ok;
    logic [FB-1:0] fr0[3];
    logic [FB-1:0] fr1[3];
    fr0[0] = 16'h0111; fr0[1] = 16'h0222; fr0[2] = 16'h0333;
    clear_mon();
    for (int i = 0; i < 3; i++) begin
      fr1[i] = FB'($urandom_range(0, 4095));
      q0.push_back(fr0[i]);
      q1.push_back(fr1[i]);
    end
    continuous = 1'b1;
    start = 1'b1;
    step(1);
    start = 1'b0;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (fall_cnt >= 2) begin ok = 1; break; end
      step(1);
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL cont_second_frame_timeout: got falls=%0d want 2", fall_cnt); end
    step(5);
    continuous = 1'b0;
    wait_idle(ok);
    step(10);
    checks++;
    if (!ok || od0.size() !== 2 || fall_cnt !== 2) begin
      errors++;
      $display("FAIL cont_frame_count: got ticks=%0d falls=%0d want 2 2", od0.size(), fall_cnt);
    end
    checks++;
    if (od0[0] !== 12'h111 || od0[1] !== 12'h222 || od1[0] !== ref_data(fr1[0]) || od1[1] !== ref_data(fr1[1])) begin
      errors++;
      $display("FAIL cont_data: got %h %h / %h %h want 111 222 / %h %h", od0[0], od0[1], od1[0], od1[1],
               ref_data(fr1[0]), ref_data(fr1[1]));
    end
    checks++;
    if (high_q[0] !== GC + 1 || low_q[1] !== FB) begin
      errors++;
      $display("FAIL cont_cs_timing: got high=%0d low2=%0d want %0d %0d", high_q[0], low_q[1], GC + 1, FB);
    end
    checks++;
    if (tcyc[1] - tcyc[0] !== FB + 1 + GC) begin
      errors++;
      $display("FAIL cont_tick_spacing: got %0d want %0d", tcyc[1] - tcyc[0], FB + 1 + GC);
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic test_reset_abort();
    bit ok;
    logic [FB-1:0] f0, f1;
    clear_mon();
    q0.push_back(16'h0FFF);
    q1.push_back(16'h0FFF);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(7);
    reset = 1'b1;
    step(1);
    checks++;
    if (CS !== 1'b1 || busy !== 1'b0 || data_out !== '0 || b_reg !== '0 || rx_done_tick !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: got cs=%b busy=%b data=%h b_reg=%h tick=%b want 1 0 0 0 0",
               CS, busy, data_out, b_reg, rx_done_tick);
    end
    reset = 1'b0;
    step(25);
    checks++;
    if (od0.size() !== 0 || data_out !== '0) begin
      errors++;
      $display("FAIL abort_no_tick: got ticks=%0d data=%h want 0 0", od0.size(), data_out);
    end
    clear_mon();
    f0 = FB'($urandom);
    f1 = FB'($urandom);
    run_single(f0, f1, ok);
    checks++;
    if (!ok || od0.size() !== 1 || od0[0] !== ref_data(f0) || od1[0] !== ref_data(f1)
        || oerr[0] !== (ref_err(f0) | ref_err(f1))) begin
      errors++;
      $display("FAIL abort_restart: got data=%h/%h err=%b want %h/%h %b", od0[0], od1[0], oerr[0],
               ref_data(f0), ref_data(f1), ref_err(f0) | ref_err(f1));
    end
  endtask

  task automatic test_start_ignored();
    bit ok;
    logic [FB-1:0] f0, f1;
    clear_mon();
    continuous = 1'b0;
    f0 = FB'($urandom_range(0, 4095));
    f1 = FB'($urandom_range(0, 4095));
    q0.push_back(f0);
    q1.push_back(f1);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(5);
    start = 1'b1;
    step(1);
    start = 1'b0;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (od0.size() >= 1) begin ok = 1; break; end
      step(1);
    end
    checks++;
    if (!ok || busy !== 1'b1) begin
      errors++;
      $display("FAIL ignore_tick_in_gap: got ok=%b busy=%b want 1 1", ok, busy);
    end
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_idle(ok);
    step(20);
    checks++;
    if (!ok || od0.size() !== 1 || fall_cnt !== 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start: got ticks=%0d falls=%0d busy=%b want 1 1 0", od0.size(), fall_cnt, busy);
    end
    checks++;
    if (od0[0] !== ref_data(f0) || od1[0] !== ref_data(f1)) begin
      errors++;
      $display("FAIL ignore_data: got %h/%h want %h/%h", od0[0], od1[0], ref_data(f0), ref_data(f1));
    end
    start = 1'b1;
    reset = 1'b1;
    step(1);
    start = 1'b0;
    reset = 1'b0;
    step(10);
    checks++;
    if (fall_cnt !== 1 || busy !== 1'b0 || CS !== 1'b1) begin
      errors++;
      $display("FAIL start_with_reset: got falls=%0d busy=%b cs=%b want 1 0 1", fall_cnt, busy, CS);
    end
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_lead_err();
    test_random_frames();
    test_continuous();
    test_reset_abort();
    test_start_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
